imm_ext_pipe: RTL and testbench
===============================

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64 only.
REQ-002 Parameter ERR_W, default 8, width of the saturating error counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 FlushD  input  1  discards all buffered entries.
REQ-006 ValidD  input  1  upstream entry valid.
REQ-007 ReadyD  output  1  block can accept an entry this cycle.
REQ-008 ImmSrcD  input  3  immediate format select.
REQ-009 InstrD  input  25  instruction bits [31:7].
REQ-010 ValidE  output  1  ImmExtE/ErrE valid.
REQ-011 ReadyE  input  1  downstream accepts this cycle.
REQ-012 ImmExtE  output  XLEN  extended immediate.
REQ-013 ErrE  output  1  entry carried an illegal format.
REQ-014 ErrCount  output  ERR_W  count of illegal-format entries accepted.

Function
REQ-015 Formats: 000 I {sext Instr[31:20]}; 001 S {sext Instr[31:25],Instr[11:7]}; 010 B {sext Instr[31],Instr[7],Instr[30:25],Instr[11:8],0}; 011 J {sext Instr[31],Instr[19:12],Instr[20],Instr[30:21],0}.
REQ-016 100 U: Instr[31:12] in bits 31:12, bits 11:0 zero; for XLEN=64, bits 63:32 sign-extended from Instr[31].
REQ-017 101 Z (CSR zimm): zero-extend Instr[19:15].
REQ-018 110 SH (shift amount): zero-extend Instr[24:20] for XLEN=32, Instr[25:20] for XLEN=64.
REQ-019 111 illegal: ImmExtE is zero and ErrE is 1 for that entry.
REQ-020 Input handshake: entry accepted when ValidD && ReadyD; output transfer when ValidE && ReadyE.
REQ-021 Storage: two entries, an output register and a skid register; ReadyD = skid register empty (registered, no combinational path from ReadyE).
REQ-022 Latency: accepted entry appears on ValidE the next cycle when the output register is empty or transferring.
REQ-023 Ordering strictly FIFO; no entry dropped or duplicated except by FlushD or rst.
REQ-024 Output held stable (ImmExtE, ErrE) while ValidE && !ReadyE.
REQ-025 Accept into skid only when output register is full and not transferring; skid drains to output register on next transfer.
REQ-026 Simultaneous accept and transfer with skid empty: new entry replaces output register, ValidE stays 1.
REQ-027 FlushD: both entries invalidated next cycle; an entry presented with FlushD is dropped; ReadyD 1 the cycle after.
REQ-028 ErrCount increments by 1 per accepted illegal entry (flush does not undo it); saturates at all-ones.

Reset
REQ-029 rst: ValidE=0, ReadyD=1 the following cycle, ImmExtE=0, ErrE=0, ErrCount=0, both entries invalid.
REQ-030 rst mid-operation overrides FlushD and all handshakes; in-flight entries lost.

Structure
REQ-031 Package imm_pkg holds enum imm_src_t (IMM_I..IMM_ILL, 3 bits) and constants for the encodings.
REQ-032 Format decode in one combinational sub-module imm_ext_core (parameter XLEN), instantiated once at the input; entries store extended values.

Verification
REQ-033 XLEN=32, ImmSrcD=000, InstrD=0xFFF00093[31:7], ReadyE=1 -> next cycle ValidE=1, ImmExtE=0xFFFFFFFF.
REQ-034 ImmSrcD=010, Instr 0xFE000EE3 -> ImmExtE=0xFFFFFFFC; ImmSrcD=011, Instr 0x0080006F -> 0x00000008.
REQ-035 XLEN=64, ImmSrcD=100, Instr 0x800000B7 -> ImmExtE=0xFFFFFFFF80000000; Instr 0x123450B7 -> 0x0000000012345000.
REQ-036 ReadyE=0, three back-to-back ValidD entries A,B,C -> A,B accepted, ReadyD=0 for C; ReadyE=1 -> A,B,C out in order, no loss.
REQ-037 Two entries buffered, FlushD=1 with ValidD=1 -> next cycle ValidE=0, ReadyD=1, presented entry not output.
REQ-038 ERR_W=2, five ImmSrcD=111 entries -> each ErrE=1, ImmExtE=0; ErrCount 1,2,3,3,3.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared immediate-format encodings for the decode-stage immediate extender.
package imm_pkg;

    localparam int unsigned INSTR_W   = 25;
    localparam int unsigned IMMSRC_W  = 3;

    localparam logic [IMMSRC_W-1:0] ENC_I   = 3'b000;
    localparam logic [IMMSRC_W-1:0] ENC_S   = 3'b001;
    localparam logic [IMMSRC_W-1:0] ENC_B   = 3'b010;
    localparam logic [IMMSRC_W-1:0] ENC_J   = 3'b011;
    localparam logic [IMMSRC_W-1:0] ENC_U   = 3'b100;
    localparam logic [IMMSRC_W-1:0] ENC_Z   = 3'b101;
    localparam logic [IMMSRC_W-1:0] ENC_SH  = 3'b110;
    localparam logic [IMMSRC_W-1:0] ENC_ILL = 3'b111;

    typedef enum logic [IMMSRC_W-1:0] {
        IMM_I   = ENC_I,
        IMM_S   = ENC_S,
        IMM_B   = ENC_B,
        IMM_J   = ENC_J,
        IMM_U   = ENC_U,
        IMM_Z   = ENC_Z,
        IMM_SH  = ENC_SH,
        IMM_ILL = ENC_ILL
    } imm_src_t;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate decode; Instr holds instruction bits [31:7], so Instr[k] is instruction bit k+7.
module imm_ext_core
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [IMMSRC_W-1:0] ImmSrc,
    input  logic [INSTR_W-1:0]  Instr,
    output logic [XLEN-1:0]     ImmExt,
    output logic                Err
);

    imm_src_t w_src;

    assign w_src = imm_src_t'(ImmSrc);

    // Signed size casts perform the sign extension to XLEN for every signed format.
    always_comb begin
        ImmExt = '0;
        Err    = 1'b0;
        case (w_src)
            IMM_I:  ImmExt = XLEN'($signed(Instr[24:13]));
            IMM_S:  ImmExt = XLEN'($signed({Instr[24:18], Instr[4:0]}));
            IMM_B:  ImmExt = XLEN'($signed({Instr[24], Instr[0], Instr[23:18],
                                            Instr[4:1], 1'b0}));
            IMM_J:  ImmExt = XLEN'($signed({Instr[24], Instr[12:5], Instr[13],
                                            Instr[23:14], 1'b0}));
            IMM_U:  ImmExt = XLEN'($signed({Instr[24:5], 12'b0}));
            IMM_Z:  ImmExt = XLEN'(Instr[12:8]);
            IMM_SH: begin
                if (XLEN == 64) ImmExt = XLEN'(Instr[18:13]);
                else            ImmExt = XLEN'(Instr[17:13]);
            end
            default: begin
                ImmExt = '0;
                Err    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate extender with a two-entry (output + skid) valid/ready buffer and a saturating illegal-format counter.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int ERR_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                FlushD,
    input  logic                ValidD,
    output logic                ReadyD,
    input  logic [IMMSRC_W-1:0] ImmSrcD,
    input  logic [INSTR_W-1:0]  InstrD,
    output logic                ValidE,
    input  logic                ReadyE,
    output logic [XLEN-1:0]     ImmExtE,
    output logic                ErrE,
    output logic [ERR_W-1:0]    ErrCount
);

    logic [XLEN-1:0]  w_imm;
    logic             w_err;
    logic             w_acc;
    logic             w_load_out;

    logic             r_out_valid;
    logic [XLEN-1:0]  r_out_imm;
    logic             r_out_err;
    logic             r_skid_valid;
    logic [XLEN-1:0]  r_skid_imm;
    logic             r_skid_err;
    logic [ERR_W-1:0] r_err_cnt;

    imm_ext_core #(
        .XLEN (XLEN)
    ) u_core (
        .ImmSrc (ImmSrcD),
        .Instr  (InstrD),
        .ImmExt (w_imm),
        .Err    (w_err)
    );

    // An entry presented together with FlushD is dropped and never counted as accepted.
    assign w_acc      = ValidD && !r_skid_valid && !FlushD;
    assign w_load_out = !r_out_valid || ReadyE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_err   <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            if (w_acc && w_err && !(&r_err_cnt))
                r_err_cnt <= r_err_cnt + ERR_W'(1);

            if (FlushD) begin
                r_out_valid  <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_load_out) begin
                // Skid entry is older than anything presented now, so it drains first.
                if (r_skid_valid) begin
                    r_out_valid  <= 1'b1;
                    r_out_imm    <= r_skid_imm;
                    r_out_err    <= r_skid_err;
                    r_skid_valid <= 1'b0;
                end else if (w_acc) begin
                    r_out_valid  <= 1'b1;
                    r_out_imm    <= w_imm;
                    r_out_err    <= w_err;
                end else begin
                    r_out_valid  <= 1'b0;
                end
            end else if (w_acc) begin
                r_skid_valid <= 1'b1;
                r_skid_imm   <= w_imm;
                r_skid_err   <= w_err;
            end
        end
    end

    assign ReadyD   = !r_skid_valid;
    assign ValidE   = r_out_valid;
    assign ImmExtE  = r_out_imm;
    assign ErrE     = r_out_err;
    assign ErrCount = r_err_cnt;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench: XLEN=32/ERR_W=2 and XLEN=64/ERR_W=8 instances share one stimulus stream against a queue model.
module tb_imm_ext_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        FlushD = 1'b0;
    logic        ValidD = 1'b0;
    logic        ReadyE = 1'b0;
    logic [2:0]  ImmSrcD = '0;
    logic [24:0] InstrD = '0;

    logic        ReadyD32, ValidE32, ErrE32;
    logic [31:0] ImmExtE32;
    logic [1:0]  ErrCount32;
    logic        ReadyD64, ValidE64, ErrE64;
    logic [63:0] ImmExtE64;
    logic [7:0]  ErrCount64;

    int n_tests = 0;
    int n_fail  = 0;

    imm_ext_pipe #(.XLEN(32), .ERR_W(2)) u_dut32 (
        .clk(clk), .rst(rst), .FlushD(FlushD), .ValidD(ValidD), .ReadyD(ReadyD32),
        .ImmSrcD(ImmSrcD), .InstrD(InstrD), .ValidE(ValidE32), .ReadyE(ReadyE),
        .ImmExtE(ImmExtE32), .ErrE(ErrE32), .ErrCount(ErrCount32)
    );

    imm_ext_pipe #(.XLEN(64), .ERR_W(8)) u_dut64 (
        .clk(clk), .rst(rst), .FlushD(FlushD), .ValidD(ValidD), .ReadyD(ReadyD64),
        .ImmSrcD(ImmSrcD), .InstrD(InstrD), .ValidE(ValidE64), .ReadyE(ReadyE),
        .ImmExtE(ImmExtE64), .ErrE(ErrE64), .ErrCount(ErrCount64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic [2:0]  src;
        logic [31:0] ins;
        logic [63:0] exp32;
        logic [63:0] exp64;
        logic        err;
    } vec_t;

    ent_t q[$];
    int   cnt32 = 0;
    int   cnt64 = 0;
    vec_t tbl[10];

    // Reference immediate built from field values with integer arithmetic.
    function automatic logic [63:0] ref_imm(input logic [2:0] s, input logic [31:0] ins, input bit x64);
        longint v;
        case (s)
            3'd0: v = longint'($signed(ins)) >>> 20;
            3'd1: v = ((longint'($signed(ins)) >>> 25) << 5) | longint'((ins >> 7) & 32'd31);
            3'd2: v = (ins[31] ? -64'sd4096 : 64'sd0) + longint'(ins[7]) * 2048
                      + longint'((ins >> 25) & 32'd63) * 32 + longint'((ins >> 8) & 32'd15) * 2;
            3'd3: v = (ins[31] ? -64'sd1048576 : 64'sd0) + longint'((ins >> 12) & 32'd255) * 4096
                      + longint'(ins[20]) * 2048 + longint'((ins >> 21) & 32'd1023) * 2;
            3'd4: v = longint'($signed(ins & 32'hFFFF_F000));
            3'd5: v = longint'((ins >> 15) & 32'd31);
            3'd6: v = x64 ? longint'((ins >> 20) & 32'd63) : longint'((ins >> 20) & 32'd31);
            default: v = 0;
        endcase
        if (!x64) v = v & 64'hFFFF_FFFF;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [63:0] e32, e64;
        logic        eerr;
        chk("ReadyD32", {63'b0, ReadyD32}, {63'b0, q.size() < 2});
        chk("ReadyD64", {63'b0, ReadyD64}, {63'b0, q.size() < 2});
        chk("ValidE32", {63'b0, ValidE32}, {63'b0, q.size() > 0});
        chk("ValidE64", {63'b0, ValidE64}, {63'b0, q.size() > 0});
        if (q.size() > 0) begin
            e32  = ref_imm(q[0].src, q[0].ins, 1'b0);
            e64  = ref_imm(q[0].src, q[0].ins, 1'b1);
            eerr = (q[0].src == 3'd7);
            chk("ImmExtE32", {32'b0, ImmExtE32}, e32);
            chk("ImmExtE64", ImmExtE64, e64);
            chk("ErrE32", {63'b0, ErrE32}, {63'b0, eerr});
            chk("ErrE64", {63'b0, ErrE64}, {63'b0, eerr});
        end
        chk("ErrCount32", {62'b0, ErrCount32}, 64'(cnt32));
        chk("ErrCount64", {56'b0, ErrCount64}, 64'(cnt64));
    endtask

    // One clock: drive inputs, compare current outputs to the model, then advance both.
    task automatic cycle(input bit vd, input bit fl, input bit rdy, input logic [2:0] src, input logic [31:0] ins);
        bit   acc, xfer;
        ent_t e;
        ValidD  = vd;
        FlushD  = fl;
        ReadyE  = rdy;
        ImmSrcD = src;
        InstrD  = ins[31:7];
        check_model();
        acc  = vd && (q.size() < 2) && !fl;
        xfer = (q.size() > 0) && rdy;
        @(posedge clk);
        #1;
        if (acc && src == 3'd7) begin
            if (cnt32 < 3)   cnt32++;
            if (cnt64 < 255) cnt64++;
        end
        if (fl) begin
            q.delete();
        end else begin
            if (xfer) void'(q.pop_front());
            if (acc) begin
                e.src = src;
                e.ins = ins;
                q.push_back(e);
            end
        end
    endtask

    // Reset asserted with busy inputs to show it overrides flush and handshakes.
    task automatic do_reset();
        rst     = 1'b1;
        ValidD  = 1'b1;
        FlushD  = 1'b1;
        ReadyE  = 1'b1;
        ImmSrcD = 3'd7;
        InstrD  = '1;
        @(posedge clk);
        #1;
        q.delete();
        cnt32 = 0;
        cnt64 = 0;
        chk("rst_ValidE32", {63'b0, ValidE32}, 64'd0);
        chk("rst_ReadyD32", {63'b0, ReadyD32}, 64'd1);
        chk("rst_ImmExtE32", {32'b0, ImmExtE32}, 64'd0);
        chk("rst_ErrE32", {63'b0, ErrE32}, 64'd0);
        chk("rst_ErrCount32", {62'b0, ErrCount32}, 64'd0);
        chk("rst_ImmExtE64", ImmExtE64, 64'd0);
        chk("rst_ErrCount64", {56'b0, ErrCount64}, 64'd0);
        rst    = 1'b0;
        ValidD = 1'b0;
        FlushD = 1'b0;
        ReadyE = 1'b0;
    endtask

    initial begin
        int unsigned exp_cnt[5];

        tbl[0] = '{3'd0, 32'hFFF0_0093, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        tbl[1] = '{3'd2, 32'hFE00_0EE3, 64'h0000_0000_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        tbl[2] = '{3'd3, 32'h0080_006F, 64'h0000_0000_0000_0008, 64'h0000_0000_0000_0008, 1'b0};
        tbl[3] = '{3'd4, 32'h8000_00B7, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0};
        tbl[4] = '{3'd4, 32'h1234_50B7, 64'h0000_0000_1234_5000, 64'h0000_0000_1234_5000, 1'b0};
        tbl[5] = '{3'd1, 32'hFE00_0C23, 64'h0000_0000_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        tbl[6] = '{3'd5, 32'h000F_8000, 64'h0000_0000_0000_001F, 64'h0000_0000_0000_001F, 1'b0};
        tbl[7] = '{3'd6, 32'h03F0_0000, 64'h0000_0000_0000_001F, 64'h0000_0000_0000_003F, 1'b0};
        tbl[8] = '{3'd7, 32'hFFFF_FFFF, 64'h0,                   64'h0,                   1'b1};
        tbl[9] = '{3'd0, 32'h7FF0_0093, 64'h0000_0000_0000_07FF, 64'h0000_0000_0000_07FF, 1'b0};
        exp_cnt = '{1, 2, 3, 3, 3};

        do_reset();

        // Table vectors: each entry appears on ValidE the cycle after acceptance.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 1'b1, tbl[i].src, tbl[i].ins);
            chk("tbl_ValidE", {63'b0, ValidE32}, 64'd1);
            chk("tbl_Imm32", {32'b0, ImmExtE32}, tbl[i].exp32);
            chk("tbl_Imm64", ImmExtE64, tbl[i].exp64);
            chk("tbl_Err", {63'b0, ErrE64}, {63'b0, tbl[i].err});
        end
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);

        // Backpressure: A,B buffered, C held off, then all three drain in order.
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0010_0000);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0020_0000);
        chk("bp_ReadyD_full", {63'b0, ReadyD32}, 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0030_0000);
        chk("bp_hold_A", {32'b0, ImmExtE32}, 64'd1);
        chk("bp_ReadyD_still", {63'b0, ReadyD32}, 64'd0);
        cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'h0030_0000);
        chk("bp_out_B", {32'b0, ImmExtE32}, 64'd2);
        chk("bp_ReadyD_free", {63'b0, ReadyD32}, 64'd1);
        cycle(1'b1, 1'b0, 1'b1, 3'd0, 32'h0030_0000);
        chk("bp_out_C", {32'b0, ImmExtE32}, 64'd3);
        chk("bp_ValidE_C", {63'b0, ValidE32}, 64'd1);
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        chk("bp_drained", {63'b0, ValidE32}, 64'd0);

        // Flush with both entries full and a new entry presented.
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0040_0000);
        cycle(1'b1, 1'b0, 1'b0, 3'd0, 32'h0050_0000);
        cycle(1'b1, 1'b1, 1'b0, 3'd0, 32'h0060_0000);
        chk("fl_ValidE", {63'b0, ValidE64}, 64'd0);
        chk("fl_ReadyD", {63'b0, ReadyD64}, 64'd1);
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        chk("fl_dropped", {63'b0, ValidE64}, 64'd0);

        // Illegal format saturation with a 2-bit counter.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 3'd7, $urandom);
            chk("ill_ErrCount32", {62'b0, ErrCount32}, 64'(exp_cnt[k]));
            chk("ill_ErrCount64", {56'b0, ErrCount64}, 64'(k + 1));
            chk("ill_ErrE", {63'b0, ErrE32}, 64'd1);
            chk("ill_Imm", {32'b0, ImmExtE32}, 64'd0);
        end

        // Random traffic against the queue model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            cycle(($urandom % 4) != 0, ($urandom % 25) == 0, ($urandom % 3) != 0,
                  3'($urandom % 8), $urandom);
        end

        // Reset in the middle of buffered traffic.
        cycle(1'b1, 1'b0, 1'b0, 3'd7, 32'h1234_5678);
        cycle(1'b1, 1'b0, 1'b0, 3'd1, 32'h8765_4321);
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
        check_model();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
